// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle
//   Execute stage of the five-stage RV32I pipeline. It resolves operand
//   forwarding, runs the ALU, computes the branch/jump decision and target
//   (both returned combinationally to fetch) and registers the EX/MEM
//   boundary.
//
// Ports
//   clk                   pipeline clock, rising edge
//   rst                   asynchronous, active-low reset
//   RD1_E, RD2_E          register-file operands from decode
//   ImmExtE               sign-extended immediate
//   PCE, PCPlus4E         instruction PC and PC+4
//   RdE                   destination register index
//   RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE   decode control
//   ALUControlE           ALU operation select
//   ResultSrcE            writeback select (passed through)
//   ForwardAE, ForwardBE  hazard-unit forwarding selects
//   ResultW               writeback-stage result (forward source)
//   PCSrcE, PCTargetE     combinational fetch redirect and its address
//   ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM
//                         EX/MEM registered outputs
// ---------------------------------------------------------------------------
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        jalrE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ResultSrcE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM
);

  logic [31:0] srcAE;
  logic [31:0] writeDataE;
  logic [31:0] srcBE;
  logic [31:0] aluResultE;
  logic [31:0] jalrSum;
  logic        zeroE;

  // Selects 10 take the EX/MEM register output, so the previous instruction's
  // result feeds the current one back-to-back; 11 falls back to the register file.
  function automatic logic [31:0] fwdSel(input logic [1:0]  sel,
                                         input logic [31:0] regVal,
                                         input logic [31:0] wbVal,
                                         input logic [31:0] memVal);
    case (sel)
      2'b01:   return wbVal;
      2'b10:   return memVal;
      default: return regVal;
    endcase
  endfunction

  function automatic logic [31:0] aluOp(input logic [2:0]  ctl,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (ctl)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, (sa < sb)};
      default: return 32'b0;
    endcase
  endfunction

  always_comb begin
    srcAE      = fwdSel(ForwardAE, RD1_E, ResultW, ALUResultM);
    writeDataE = fwdSel(ForwardBE, RD2_E, ResultW, ALUResultM);
    srcBE      = ALUSrcE ? ImmExtE : writeDataE;
    aluResultE = aluOp(ALUControlE, srcAE, srcBE);
    zeroE      = (aluResultE == 32'b0);
    jalrSum    = srcAE + ImmExtE;
    // jalr clears bit 0 of the target; jal/branch are PC-relative.
    PCTargetE  = jalrE ? (jalrSum & 32'hFFFF_FFFE) : (PCE + ImmExtE);
    // Branch is equality-only: decode programs a subtract, zero means taken.
    PCSrcE     = JumpE | jalrE | (BranchE & zeroE);
  end

  // EX/MEM boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultM <= 32'b0;
      WriteDataM <= 32'b0;
      PCPlus4M   <= 32'b0;
      RdM        <= 5'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b0;
    end else begin
      ALUResultM <= aluResultE;
      WriteDataM <= writeDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// ---------------------------------------------------------------------------
// tb_execute_cycle
//   Self-checking bench for execute_cycle: directed steps from the test plan
//   followed by randomized instructions, all checked against a behavioural
//   reference model of the execute stage.
// ---------------------------------------------------------------------------
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;

  int checks = 0;
  int errors = 0;

  // Model's view of the EX/MEM ALU result (forwarding source for select 10).
  logic [31:0] expAluM;

  logic [2:0]  sweepCode [6];
  logic [31:0] sweepExp  [6];

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: operand source chosen by the forwarding select.
  function automatic logic [31:0] refOperand(input logic [1:0] sel, input logic [31:0] regVal);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return expAluM;
    return regVal;
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] ctl, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ctl == 3'd0) return a + b;
    if (ctl == 3'd1) return a - b;
    if (ctl == 3'd2) return a & b;
    if (ctl == 3'd3) return a | b;
    if (ctl == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic clearInputs();
    RD1_E = 0; RD2_E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RdE = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; jalrE = 0; BranchE = 0;
    ALUSrcE = 0; ALUControlE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic checkZeros(input string tag);
    chk({tag, ".ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, ".WriteDataM"}, WriteDataM, 32'd0);
    chk({tag, ".PCPlus4M"},   PCPlus4M,   32'd0);
    chk({tag, ".RdM"},        {27'd0, RdM}, 32'd0);
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, 32'd0);
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, 32'd0);
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, 32'd0);
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // combinational redirect, clocks once and checks the EX/MEM outputs.
  task automatic step(input string tag);
    logic [31:0] a, wd, b, r, tgt;
    logic        ps;
    a   = refOperand(ForwardAE, RD1_E);
    wd  = refOperand(ForwardBE, RD2_E);
    b   = ALUSrcE ? ImmExtE : wd;
    r   = refAlu(ALUControlE, a, b);
    tgt = jalrE ? ((a + ImmExtE) & ~32'd1) : (PCE + ImmExtE);
    ps  = JumpE | jalrE | (BranchE & (r == 32'd0));
    #1;
    chk({tag, ".PCSrcE"},    {31'd0, PCSrcE}, {31'd0, ps});
    chk({tag, ".PCTargetE"}, PCTargetE, tgt);
    @(posedge clk);
    #1;
    chk({tag, ".ALUResultM"}, ALUResultM, r);
    chk({tag, ".WriteDataM"}, WriteDataM, wd);
    chk({tag, ".PCPlus4M"},   PCPlus4M, PCPlus4E);
    chk({tag, ".RdM"},        {27'd0, RdM}, {27'd0, RdE});
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, RegWriteE});
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, MemWriteE});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, ResultSrcE});
    expAluM = r;
    @(negedge clk);
  endtask

  initial begin
    sweepCode = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    sweepExp  = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0};

    // Power-on reset
    clearInputs();
    rst = 1'b0;
    expAluM = 32'd0;
    @(negedge clk);
    checkZeros("por");
    rst = 1'b1;

    // add 5 + 7
    RD1_E = 5; RD2_E = 7; ALUControlE = 3'd0; RegWriteE = 1; RdE = 5'd3;
    PCPlus4E = 32'h8;
    step("add57");
    chk("add57.const", ALUResultM, 32'd12);

    // ALU sweep with -1 and 1
    clearInputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    for (int i = 0; i < 6; i++) begin
      ALUControlE = sweepCode[i];
      step($sformatf("sweep%0d", sweepCode[i]));
      chk($sformatf("sweep%0d.const", sweepCode[i]), ALUResultM, sweepExp[i]);
    end

    // Back-to-back forwarding from EX/MEM, then from writeback
    clearInputs();
    RD1_E = 4; RD2_E = 6; ALUControlE = 3'd0; RegWriteE = 1; RdE = 5'd7;
    step("fwd.i1");
    chk("fwd.i1.const", ALUResultM, 32'd10);
    ForwardAE = 2'b10; RD1_E = 99; ImmExtE = 3; ALUSrcE = 1;
    step("fwd.i2");
    chk("fwd.i2.const", ALUResultM, 32'd13);
    ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'h55; MemWriteE = 1; RegWriteE = 0;
    step("fwd.i3");
    chk("fwd.i3.const", WriteDataM, 32'h55);

    // Branch taken / not taken
    clearInputs();
    BranchE = 1; ALUControlE = 3'd1; RD1_E = 4; RD2_E = 4;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #1;
    chk("beq.taken.const", {31'd0, PCSrcE}, 32'd1);
    chk("beq.target.const", PCTargetE, 32'hF0);
    step("beq.taken");
    RD2_E = 5;
    #1;
    chk("beq.nt.const", {31'd0, PCSrcE}, 32'd0);
    step("beq.nt");

    // jalr with operand forwarded from writeback
    clearInputs();
    jalrE = 1; ForwardAE = 2'b01; ResultW = 32'h203; RD1_E = 32'hDEAD; ImmExtE = 2;
    RegWriteE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h44; RdE = 5'd1;
    #1;
    chk("jalr.target.const", PCTargetE, 32'h204);
    chk("jalr.pcsrc.const", {31'd0, PCSrcE}, 32'd1);
    step("jalr");
    chk("jalr.pc4.const", PCPlus4M, 32'h44);
    chk("jalr.rsrc.const", {30'd0, ResultSrcM}, 32'd2);

    // jal with PC wrap-around
    clearInputs();
    JumpE = 1; PCE = 32'hFFFF_FFFC; ImmExtE = 8;
    #1;
    chk("jal.target.const", PCTargetE, 32'h4);
    chk("jal.pcsrc.const", {31'd0, PCSrcE}, 32'd1);
    step("jal");

    // Bubble: zero control with equal operands must not redirect
    clearInputs();
    RD1_E = 32'h1234; RD2_E = 32'h1234; ALUControlE = 3'd1;
    #1;
    chk("bubble.const", {31'd0, PCSrcE}, 32'd0);
    step("bubble");

    // Reset mid-cycle with a write in flight
    clearInputs();
    RD1_E = 32'h77; RegWriteE = 1; MemWriteE = 1; RdE = 5'd9; ResultSrcE = 2'b01;
    PCPlus4E = 32'h300;
    step("prereset");
    #2;
    rst = 1'b0;
    #1;
    checkZeros("midreset");
    @(negedge clk);
    checkZeros("midreset.held");
    rst = 1'b1;
    expAluM = 32'd0;
    clearInputs();
    RD1_E = 5; RD2_E = 7; ALUControlE = 3'd0; RegWriteE = 1;
    step("postreset");
    chk("postreset.const", ALUResultM, 32'd12);

    // Randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      RD1_E       = $urandom;
      RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      ImmExtE     = $urandom;
      PCE         = $urandom;
      PCPlus4E    = PCE + 32'd4;
      ResultW     = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
      RdE         = 5'($urandom_range(0, 31));
      RegWriteE   = 1'($urandom_range(0, 1));
      MemWriteE   = 1'($urandom_range(0, 1));
      JumpE       = ($urandom_range(0, 5) == 0);
      jalrE       = ($urandom_range(0, 5) == 0);
      BranchE     = 1'($urandom_range(0, 1));
      ALUSrcE     = 1'($urandom_range(0, 1));
      ALUControlE = 3'($urandom_range(0, 7));
      ResultSrcE  = 2'($urandom_range(0, 3));
      ForwardAE   = 2'($urandom_range(0, 3));
      ForwardBE   = 2'($urandom_range(0, 3));
      step($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
